// File: rtl/jogador_automatico_if.sv
// Game <-> auto-player link: leds/status from the game, button drive back to it.
interface jogador_automatico_if;
  logic [3:0] leds;
  logic       vez_jogador;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic [3:0] botoes;

  modport master (output leds, vez_jogador, pronto, ganhou, perdeu, input botoes);
  modport slave  (input leds, vez_jogador, pronto, ganhou, perdeu, output botoes);
endinterface

// File: rtl/jogador_automatico.sv
// Memory-game auto-player: captures the presented led sequence and replays it on
// the buttons with fixed hold/release timing, optionally corrupting one press.
module jogador_automatico #(
  parameter int MAX_JOGADAS  = 16,
  parameter int HOLD_CICLOS  = 3,
  parameter int SOLTA_CICLOS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 habilita,
  input  logic                 erro_en,
  input  logic [4:0]           erro_rodada,
  input  logic [3:0]           erro_jogada,
  jogador_automatico_if.slave  jogo,
  output logic                 ativo,
  output logic [4:0]           rodadas_jogadas,
  output logic                 resultado_ganhou,
  output logic                 resultado_perdeu,
  output logic                 erro_captura,
  output logic [3:0]           db_estado
);

  localparam int NW   = $clog2(MAX_JOGADAS + 1);
  localparam int IW   = $clog2(MAX_JOGADAS);
  localparam int CMAX = (HOLD_CICLOS > SOLTA_CICLOS) ? HOLD_CICLOS : SOLTA_CICLOS;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    INATIVO   = 4'd0,
    CAPTURA   = 4'd1,
    PRESSIONA = 4'd2,
    SOLTA     = 4'd3,
    AGUARDA   = 4'd4,
    FIM       = 4'd5,
    FALHA     = 4'd6
  } estado_t;

  estado_t                        estado;
  logic [MAX_JOGADAS-1:0][3:0]    mem;
  logic [NW-1:0]                  n, i, i_nxt;
  logic [CW-1:0]                  cnt;
  logic [4:0]                     rodada;
  logic [3:0]                     leds_prev, botoes_q;
  logic [3:0]                     tecla0, tecla_nxt;
  logic                           borda, multi;

  assign borda     = (leds_prev == 4'b0000) && (jogo.leds != 4'b0000);
  assign multi     = |(jogo.leds & (jogo.leds - 4'd1));
  assign i_nxt     = i + 1'b1;
  assign jogo.botoes = botoes_q;
  assign db_estado = estado;
  assign ativo     = (estado == CAPTURA) || (estado == PRESSIONA) ||
                     (estado == SOLTA)   || (estado == AGUARDA);

  // Value for the press about to start; injection rotates the one-hot left.
  always_comb begin
    tecla0    = mem[0];
    tecla_nxt = mem[i_nxt[IW-1:0]];
    if (erro_en && rodada == erro_rodada && NW'(erro_jogada) == NW'(0))
      tecla0 = {mem[0][2:0], mem[0][3]};
    if (erro_en && rodada == erro_rodada && NW'(erro_jogada) == i_nxt)
      tecla_nxt = {tecla_nxt[2:0], tecla_nxt[3]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado           <= INATIVO;
      mem              <= '0;
      n                <= '0;
      i                <= '0;
      cnt              <= '0;
      rodada           <= '0;
      leds_prev        <= '0;
      botoes_q         <= '0;
      rodadas_jogadas  <= '0;
      resultado_ganhou <= 1'b0;
      resultado_perdeu <= 1'b0;
      erro_captura     <= 1'b0;
    end else begin
      leds_prev <= jogo.leds;
      if (!habilita) begin
        estado   <= INATIVO;
        botoes_q <= '0;
      end else if (jogo.pronto && ativo) begin
        estado           <= FIM;
        botoes_q         <= '0;
        resultado_ganhou <= jogo.ganhou;
        resultado_perdeu <= jogo.perdeu;
      end else begin
        case (estado)
          INATIVO: begin
            estado           <= CAPTURA;
            n                <= '0;
            rodada           <= '0;
            resultado_ganhou <= 1'b0;
            resultado_perdeu <= 1'b0;
            erro_captura     <= 1'b0;
          end
          CAPTURA: begin
            if (borda && n == NW'(MAX_JOGADAS)) begin
              estado <= FALHA;
            end else if (jogo.vez_jogador) begin
              if (n == '0) estado <= FALHA;
              else begin
                estado   <= PRESSIONA;
                i        <= '0;
                cnt      <= '0;
                botoes_q <= tecla0;
              end
            end else if (borda) begin
              mem[n[IW-1:0]] <= jogo.leds;
              n              <= n + 1'b1;
              if (multi) erro_captura <= 1'b1;
            end
          end
          PRESSIONA: begin
            if (cnt == CW'(HOLD_CICLOS - 1)) begin
              estado   <= SOLTA;
              cnt      <= '0;
              botoes_q <= '0;
            end else cnt <= cnt + 1'b1;
          end
          SOLTA: begin
            if (cnt == CW'(SOLTA_CICLOS - 1)) begin
              cnt <= '0;
              i   <= i_nxt;
              if (i_nxt == n) begin
                estado <= AGUARDA;
                if (rodadas_jogadas != 5'd31) rodadas_jogadas <= rodadas_jogadas + 1'b1;
              end else begin
                estado   <= PRESSIONA;
                botoes_q <= tecla_nxt;
              end
            end else cnt <= cnt + 1'b1;
          end
          AGUARDA: begin
            if (!jogo.vez_jogador) begin
              estado <= CAPTURA;
              if (rodada != 5'd31) rodada <= rodada + 1'b1;
              // The next presentation may start in this very cycle.
              if (borda) begin
                mem[0] <= jogo.leds;
                n      <= NW'(1);
                if (multi) erro_captura <= 1'b1;
              end else n <= '0;
            end
          end
          FIM, FALHA: botoes_q <= '0;
          default: begin
            estado   <= INATIVO;
            botoes_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico: expected presses are queued by the
// stimulus and popped by a monitor that watches the button drive.
module tb_jogador_automatico;
  localparam int HOLD  = 3;
  localparam int SOLTA = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita, erro_en;
  logic [4:0] erro_rodada;
  logic [3:0] erro_jogada;
  logic       ativo, resultado_ganhou, resultado_perdeu, erro_captura;
  logic [4:0] rodadas_jogadas;
  logic [3:0] db_estado;

  jogador_automatico_if jif ();

  jogador_automatico #(.MAX_JOGADAS(16), .HOLD_CICLOS(HOLD), .SOLTA_CICLOS(SOLTA)) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .erro_en(erro_en),
    .erro_rodada(erro_rodada), .erro_jogada(erro_jogada), .jogo(jif),
    .ativo(ativo), .rodadas_jogadas(rodadas_jogadas),
    .resultado_ganhou(resultado_ganhou), .resultado_perdeu(resultado_perdeu),
    .erro_captura(erro_captura), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct { logic [3:0] v; bit gap_chk; } exp_t;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: each press is a run of identical non-zero botoes samples.
  int         run = 0, zrun = 0, gap = 0;
  logic [3:0] cur = '0;
  always @(negedge clock) begin
    if (!reset) begin
      run = 0; zrun = 0;
    end else if (jif.botoes != 4'b0000) begin
      if (run == 0) begin gap = zrun; cur = jif.botoes; end
      run++;
      zrun = 0;
    end else begin
      if (run > 0) begin
        if (exp_q.size() == 0) chk("unexpected_press", {28'h0, cur}, 32'h0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("press_value", {28'h0, cur}, {28'h0, e.v});
          chk("press_hold", run, HOLD);
          if (e.gap_chk) chk("release_gap", gap, SOLTA);
        end
        run = 0;
      end
      zrun++;
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; habilita = 1'b0; erro_en = 1'b0; erro_rodada = '0; erro_jogada = '0;
    jif.leds = '0; jif.vez_jogador = 1'b0; jif.pronto = 1'b0;
    jif.ganhou = 1'b0; jif.perdeu = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    habilita = 1'b1;
    tick(1);
  endtask

  task automatic show(input logic [3:0] v);
    jif.leds = v;  tick(5);
    jif.leds = '0; tick(5);
  endtask

  task automatic show3_expect(input logic [3:0] a, b, c);
    show(4'b0001); show(4'b0100); show(4'b0010);
    exp_q.push_back('{a, 1'b0});
    exp_q.push_back('{b, 1'b1});
    exp_q.push_back('{c, 1'b1});
  endtask

  initial begin
    do_reset();
    chk("reset_state", db_estado, 4'd1);
    chk("reset_rodadas", rodadas_jogadas, 5'd0);

    // Async reset in the middle of a press
    show(4'b0100);
    jif.vez_jogador = 1'b1;
    tick(1);
    chk("press_before_reset", jif.botoes, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("async_botoes", jif.botoes, 4'b0000);
    chk("async_estado", db_estado, 4'd0);

    // One full round
    do_reset();
    show3_expect(4'b0001, 4'b0100, 4'b0010);
    jif.vez_jogador = 1'b1;
    tick(25);
    chk("round_estado", db_estado, 4'd4);
    chk("round_count", rodadas_jogadas, 5'd1);
    chk("round_ativo", ativo, 1'b1);
    jif.vez_jogador = 1'b0;
    tick(1);
    chk("back_to_captura", db_estado, 4'd1);

    // Injection on press 1 of round 0, then a clean round 1
    do_reset();
    erro_en = 1'b1; erro_rodada = 5'd0; erro_jogada = 4'd1;
    show3_expect(4'b0001, 4'b1000, 4'b0010);
    jif.vez_jogador = 1'b1;
    tick(25);
    jif.vez_jogador = 1'b0;
    tick(1);
    show3_expect(4'b0001, 4'b0100, 4'b0010);
    jif.vez_jogador = 1'b1;
    tick(25);
    chk("inj_round_count", rodadas_jogadas, 5'd2);
    jif.vez_jogador = 1'b0;

    // Empty capture
    do_reset();
    jif.vez_jogador = 1'b1;
    tick(2);
    chk("empty_estado", db_estado, 4'd6);
    chk("empty_botoes", jif.botoes, 4'b0000);
    chk("empty_ativo", ativo, 1'b0);
    habilita = 1'b0;
    tick(1);
    chk("empty_abort", db_estado, 4'd0);

    // Overflow: 17 edges
    do_reset();
    for (int k = 0; k < 17; k++) begin
      jif.leds = 4'b0001 << (k % 4);
      tick(1);
      if (k == 15) chk("sixteen_edges_ok", db_estado, 4'd1);
      if (k == 16) chk("overflow_falha", db_estado, 4'd6);
      jif.leds = '0;
      tick(1);
    end

    // Non-one-hot capture, then pronto wins over vez_jogador falling
    do_reset();
    show(4'b0011);
    exp_q.push_back('{4'b0011, 1'b0});
    chk("multi_flag", erro_captura, 1'b1);
    jif.vez_jogador = 1'b1;
    tick(10);
    chk("fim_pre_estado", db_estado, 4'd4);
    jif.pronto = 1'b1; jif.ganhou = 1'b1; jif.vez_jogador = 1'b0;
    tick(1);
    chk("fim_estado", db_estado, 4'd5);
    chk("fim_ganhou", resultado_ganhou, 1'b1);
    chk("fim_perdeu", resultado_perdeu, 1'b0);
    jif.pronto = 1'b0; jif.ganhou = 1'b0;
    tick(2);
    chk("fim_latched", resultado_ganhou, 1'b1);
    chk("fim_stays", db_estado, 4'd5);
    habilita = 1'b0;
    tick(1);
    chk("fim_abort", db_estado, 4'd0);

    tick(3);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
